// File: rtl/onehot_decoder_seq_if.sv
// rtl/onehot_decoder_seq_if.sv - index-in / one-hot-out handshake bundle for onehot_decoder_seq
interface onehot_decoder_seq_if #(
    parameter int IDX_W  = 3,
    parameter int OUT_W  = 8,
    parameter int HOLD_W = 4,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [IDX_W-1:0]  in_idx;
    logic [HOLD_W-1:0] in_gap;
    logic              out_valid;
    logic [OUT_W-1:0]  out_onehot;
    logic              out_ack;
    logic              err_oob;
    logic [CNT_W-1:0]  xfer_cnt;

    modport master (
        output in_valid, in_idx, in_gap, out_ack,
        input  in_ready, out_valid, out_onehot, err_oob, xfer_cnt
    );

    modport slave (
        input  in_valid, in_idx, in_gap, out_ack,
        output in_ready, out_valid, out_onehot, err_oob, xfer_cnt
    );
endinterface

// File: rtl/onehot_decoder_seq.sv
// rtl/onehot_decoder_seq.sv - binary index to registered one-hot with ack hold and guard gap
module onehot_decoder_seq #(
    parameter int IDX_W  = 3,
    parameter int OUT_W  = 8,
    parameter int HOLD_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    onehot_decoder_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t            state;
    logic [HOLD_W-1:0] gap_lat;
    logic [HOLD_W-1:0] gap_cnt;
    logic              out_valid_r;
    logic [OUT_W-1:0]  out_onehot_r;
    logic              err_oob_r;
    logic [CNT_W-1:0]  xfer_cnt_r;
    logic              idx_oob;

    // Zero-extend so the bound test also works when OUT_W == 2**IDX_W.
    assign idx_oob = ({{(32-IDX_W){1'b0}}, bus.in_idx} >= 32'(OUT_W));

    assign bus.in_ready   = (state == IDLE);
    assign bus.out_valid  = out_valid_r;
    assign bus.out_onehot = out_onehot_r;
    assign bus.err_oob    = err_oob_r;
    assign bus.xfer_cnt   = xfer_cnt_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            gap_lat      <= '0;
            gap_cnt      <= '0;
            out_valid_r  <= 1'b0;
            out_onehot_r <= '0;
            err_oob_r    <= 1'b0;
            xfer_cnt_r   <= '0;
        end else begin
            err_oob_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (idx_oob) begin
                            err_oob_r <= 1'b1;
                        end else begin
                            gap_lat      <= bus.in_gap;
                            out_onehot_r <= OUT_W'(1) << bus.in_idx;
                            out_valid_r  <= 1'b1;
                            state        <= DRIVE;
                        end
                    end
                end
                DRIVE: begin
                    if (bus.out_ack) begin
                        out_valid_r  <= 1'b0;
                        out_onehot_r <= '0;
                        xfer_cnt_r   <= xfer_cnt_r + 1'b1;
                        if (gap_lat == '0) begin
                            state <= IDLE;
                        end else begin
                            gap_cnt <= gap_lat;
                            state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    // Leaving on count==1 yields exactly gap_lat blocked cycles.
                    gap_cnt <= gap_cnt - 1'b1;
                    if (gap_cnt == HOLD_W'(1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/onehot_decoder_seq.md
Name: onehot_decoder_seq

Overview:
Sequential inverse of the 8-to-3 priority encoder. Accepts a binary index over a valid/ready handshake and drives the matching registered one-hot vector until the consumer acknowledges it. After each acknowledge it enforces a programmable guard gap before accepting the next index. It sits on the grant path downstream of the encoder and turns the encoded winner back into a one-hot select line.

Parameters:
IDX_W, 3, width of the binary index input.
OUT_W, 8, width of the one-hot output. Must satisfy OUT_W <= 2**IDX_W.
HOLD_W, 4, width of the guard-gap length field and its counter.
CNT_W, 8, width of the completed-transfer counter.

Ports:
clk  in  1  rising-edge clock, single clock domain.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  in_idx/in_gap are valid this cycle.
in_ready  out  1  block can accept an index; equals (state==IDLE).
in_idx  in  IDX_W  binary index to decode.
in_gap  in  HOLD_W  number of guard cycles inserted after the acknowledge.
out_valid  out  1  out_onehot holds a decoded value.
out_onehot  out  OUT_W  registered one-hot; all zero when out_valid=0.
out_ack  in  1  consumer acknowledge; only meaningful while out_valid=1.
err_oob  out  1  one-cycle pulse: an accepted index had in_idx >= OUT_W.
xfer_cnt  out  CNT_W  count of acknowledged transfers; wraps modulo 2**CNT_W.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, out_valid=0, out_onehot=0, err_oob=0, xfer_cnt=0, gap counter=0.
  - Reset takes effect immediately, including mid-DRIVE or mid-GAP. No partial output survives.
- All outputs are registered except in_ready, which is decoded combinationally from state only (no in_valid→in_ready path).
- States: IDLE, DRIVE, GAP.
- IDLE:
  - Accept occurs on a clock edge with in_valid=1 and in_ready=1.
  - If in_idx < OUT_W: latch in_gap; out_onehot <= (1 << in_idx); out_valid <= 1; go to DRIVE.
  - If in_idx >= OUT_W: drop the item; err_oob <= 1 for exactly one cycle; stay in IDLE. out_valid and xfer_cnt are unchanged.
  - err_oob returns to 0 on the next edge.
- DRIVE:
  - out_onehot and out_valid are held stable until out_ack=1 is sampled at an edge. Input changes are ignored because in_ready=0.
  - On an ack edge: out_valid <= 0; out_onehot <= 0; xfer_cnt <= xfer_cnt+1 (wraps from 2**CNT_W-1 to 0).
  - Then: if the latched gap == 0, go to IDLE; otherwise load the gap counter with the latched gap and go to GAP.
- GAP:
  - The gap counter decrements every edge.
  - On the edge where the counter equals 1, go to IDLE. This gives exactly gap cycles with in_ready=0 and out_valid=0.
- Timing:
  - Accept at edge A → out_valid visible after A (latency 1).
  - Ack at edge M → earliest next accept at edge M+1+gap.
  - Maximum throughput with gap=0 and ack held high: one transfer per 2 cycles.
- out_ack while out_valid=0 is ignored in every state.
- in_gap = 2**HOLD_W-1 gives the maximum gap (15 cycles at default). There is no overflow.
- Invariant: out_onehot has exactly one bit set iff out_valid=1; otherwise it is all zero.

Test Plan:
- Reset: assert rst_n=0 mid-DRIVE (out_onehot=8'b0010_0000) → all outputs go to 0 immediately (asynchronous); after release, in_ready=1 and xfer_cnt=0.
- Full sweep: in_idx=0..7, gap=0, ack held 1 → out_onehot=8'b0000_0001…8'b1000_0000, one transfer per 2 cycles, xfer_cnt=8 at end.
- Hold-until-ack: in_idx=5, ack delayed 6 cycles, in_idx changed to 2 meanwhile → out_onehot stays 8'b0010_0000 for 6 cycles; in_ready=0 throughout.
- Guard gap: in_idx=3, in_gap=4, ack at edge M → in_ready=0 for edges M+1..M+4; next accept at M+5; out_valid=0 during the gap.
- Out-of-bound: OUT_W=6, in_idx=7 → err_oob=1 for one cycle, out_valid stays 0, xfer_cnt unchanged, in_ready stays 1.
- Counter wrap: 256 transfers with CNT_W=8 → xfer_cnt goes 255→0; an out_ack with out_valid=0 does not increment it.
